// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch stage and imem
interface fetch_unit_if #(parameter int ADDR_W = 32);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       rdata;
  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem requester and IF/ID driver with stall/redirect handling
module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc,
  fetch_unit_if.master          imem,
  output logic [2*ADDR_W-1:0]   if_data,
  output logic                  if_write,
  output logic                  if_flush
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, tgt, tgt_n, pc4, rpc;
  logic [31:0]       hold_instr, hold_n;
  assign pc4       = pc + ADDR_W'(4);
  assign rpc       = redirect_pc & ~ADDR_W'(3);
  assign imem.addr = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      tgt        <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      tgt        <= tgt_n;
      hold_instr <= hold_n;
    end
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    tgt_n    = tgt;
    hold_n   = hold_instr;
    imem.req = 1'b0;
    if_write = 1'b0;
    if_flush = 1'b0;
    if_data  = {pc4, ADDR_W'(imem.rdata)};
    case (state)
      FETCH: begin
        imem.req = 1'b1;
        if (redirect) begin
          if_flush = 1'b1;
          if (imem.ready) pc_n = rpc;
          else begin
            tgt_n   = rpc;
            state_n = DISCARD;
          end
        end else if (imem.ready && !stall) begin
          if_write = 1'b1;
          pc_n     = pc4;
        end else if (imem.ready) begin
          hold_n  = imem.rdata;
          state_n = HOLD;
        end else if_flush = !stall;
      end
      HOLD: begin
        if_data = {pc4, ADDR_W'(hold_instr)};
        if (redirect) begin
          if_flush = 1'b1;
          pc_n     = rpc;
          state_n  = FETCH;
        end else if (!stall) begin
          if_write = 1'b1;
          pc_n     = pc4;
          state_n  = FETCH;
        end
      end
      DISCARD: begin
        // the outstanding request must complete before the new target can be issued
        imem.req = 1'b1;
        if_flush = redirect || !stall;
        if (redirect) tgt_n = rpc;
        if (imem.ready) begin
          pc_n    = redirect ? rpc : tgt;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
    if (!rst_n) begin
      imem.req = 1'b0;
      if_write = 1'b0;
      if_flush = 1'b0;
      if_data  = '0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with an IF/ID write scoreboard for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [63:0] if_data;
  logic        if_write, if_flush;
  int          checks = 0, failures = 0;
  logic [63:0] sb[$];
  fetch_unit_if #(.ADDR_W(32)) bus();
  assign bus.rdata = bus.addr ^ 32'hA5A5A5A5;
  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus.master),
    .if_data(if_data), .if_write(if_write), .if_flush(if_flush));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    @(posedge clk);
    #1;
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    bus.ready = rdy;
  endtask
  task automatic look(input string tag, input bit req, input logic [31:0] addr, input bit wr, input bit fl);
    @(negedge clk);
    chk({tag, ".req"}, 64'(bus.req), 64'(req));
    if (req) chk({tag, ".addr"}, 64'(bus.addr), 64'(addr));
    chk({tag, ".write"}, 64'(if_write), 64'(wr));
    chk({tag, ".flush"}, 64'(if_flush), 64'(fl));
  endtask
  function automatic logic [63:0] word(input logic [31:0] a);
    return {a + 32'd4, a ^ 32'hA5A5A5A5};
  endfunction
  always @(negedge clk)
    if (if_write) begin
      if (sb.size() == 0) chk("unexpected_write", 64'(if_write), 64'(0));
      else chk("if_data", if_data, sb.pop_front());
    end
  initial begin
    bus.ready = 1'b1;
    @(negedge clk);
    chk("rst.req", 64'(bus.req), 64'(0));
    chk("rst.write", 64'(if_write), 64'(0));
    chk("rst.flush", 64'(if_flush), 64'(0));
    chk("rst.data", if_data, 64'(0));
    cyc(0, 0, 0, 1); rst_n = 1'b1;
    sb.push_back(64'h00000004_A5A5A5A5);
    look("c0", 1, 32'h0, 1, 0);
    cyc(0, 0, 0, 1); sb.push_back(word(32'h4));
    look("c1", 1, 32'h4, 1, 0);
    cyc(1, 0, 0, 1);
    look("c2_stall", 1, 32'h8, 0, 0);
    cyc(1, 0, 0, 1);
    look("c3_hold", 0, 32'h8, 0, 0);
    cyc(1, 0, 0, 1);
    look("c4_hold", 0, 32'h8, 0, 0);
    cyc(0, 0, 0, 1); sb.push_back(word(32'h8));
    look("c5_release", 0, 32'h8, 1, 0);
    cyc(0, 0, 0, 1); sb.push_back(word(32'hC));
    look("c6", 1, 32'hC, 1, 0);
    cyc(0, 1, 32'h103, 0);
    look("c7_redir", 1, 32'h10, 0, 1);
    cyc(0, 0, 0, 0);
    look("c8_discard", 1, 32'h10, 0, 1);
    cyc(0, 0, 0, 1);
    look("c9_drop", 1, 32'h10, 0, 1);
    cyc(0, 0, 0, 1); sb.push_back(word(32'h100));
    look("c10_tgt", 1, 32'h100, 1, 0);
    cyc(1, 0, 0, 1);
    look("c11_stall", 1, 32'h104, 0, 0);
    cyc(1, 1, 32'h200, 1);
    look("c12_hold_redir", 0, 32'h104, 0, 1);
    cyc(0, 1, 32'hFFFF_FFFE, 1);
    look("c13_redir", 1, 32'h200, 0, 1);
    cyc(0, 0, 0, 1); sb.push_back(word(32'hFFFF_FFFC));
    look("c14_wrap", 1, 32'hFFFF_FFFC, 1, 0);
    chk("c14_wrap.pc4", 64'(if_data[63:32]), 64'(0));
    cyc(0, 1, 32'h300, 0);
    look("c15_redir", 1, 32'h0, 0, 1);
    cyc(1, 0, 0, 0);
    look("c16_discard_stall", 1, 32'h0, 0, 0);
    #1 rst_n = 1'b0;
    bus.ready = 1'b1;
    #1;
    chk("async_rst.req", 64'(bus.req), 64'(0));
    chk("async_rst.write", 64'(if_write), 64'(0));
    chk("async_rst.flush", 64'(if_flush), 64'(0));
    cyc(0, 0, 0, 1);
    look("c17_in_rst", 0, 32'h0, 0, 0);
    chk("c17_in_rst.data", if_data, 64'(0));
    cyc(0, 0, 0, 0); rst_n = 1'b1;
    look("c18_post_rst", 1, 32'h0, 0, 1);
    cyc(0, 0, 0, 1); sb.push_back(word(32'h0));
    look("c19", 1, 32'h0, 1, 0);
    cyc(0, 0, 0, 1); sb.push_back(word(32'h4));
    look("c20", 1, 32'h4, 1, 0);
    @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
